// File: rtl/mem_be_pipe.sv
// Single-port word memory with byte enables, a READ_LAT-deep read pipeline and an
// optional zeroing sweep after reset. Storage and read stages are split into byte lanes.

module mem_be_lane #(
    parameter int DEPTH      = 64,
    parameter int ADDR_WIDTH = 6,
    parameter int READ_LAT   = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [7:0]            wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    input  logic                  rzero_i,
    input  logic [READ_LAT-1:0]   vld_i,
    output logic [7:0]            rdata_o
);
    logic [7:0] mem_q   [DEPTH];
    logic [7:0] stage_q [READ_LAT];

    // Storage has no reset so contents survive reset when the clear sweep is disabled.
    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    // Each stage only loads when a read enters it, so the last stage holds between pulses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < READ_LAT; i++) stage_q[i] <= '0;
        end else begin
            if (vld_i[0]) stage_q[0] <= rzero_i ? 8'h00 : mem_q[raddr_i];
            for (int i = 1; i < READ_LAT; i++) begin
                if (vld_i[i]) stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign rdata_o = stage_q[READ_LAT-1];
endmodule

module mem_be_pipe #(
    parameter int WIDTH          = 32,
    parameter int DEPTH          = 64,
    parameter int ADDR_WIDTH     = $clog2(DEPTH),
    parameter int READ_LAT       = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic                  wr_rd_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [WIDTH-1:0]      wdata_i,
    input  logic [WIDTH/8-1:0]    be_i,
    output logic [WIDTH-1:0]      rdata_o,
    output logic                  rvalid_o,
    output logic                  err_o
);
    localparam int NUM_LANES = WIDTH / 8;
    localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef struct packed {
        logic                  wr;
        logic [ADDR_WIDTH-1:0] addr;
        logic [WIDTH-1:0]      wdata;
        logic [NUM_LANES-1:0]  be;
    } req_t;

    typedef enum logic {INIT, RUN} state_e;

    req_t                  req;
    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
    logic                  run, clr_we;
    logic                  acc, in_range, wr_acc, rd_acc;
    logic                  wr_err_q;
    logic [READ_LAT-1:0]   vld_q, err_q;
    logic [READ_LAT:0]     vld_pipe, err_pipe;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [NUM_LANES-1:0]  lane_we;
    logic [NUM_LANES-1:0][7:0] lane_wdata, lane_rdata;

    assign req = '{wr: wr_rd_i, addr: addr_i, wdata: wdata_i, be: be_i};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= (CLEAR_ON_RESET != 0) ? INIT : RUN;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            INIT: begin
                if (clr_cnt_q == LAST_ADDR) begin
                    state_d   = RUN;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
                end
            end
            RUN:     ;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        run    = 1'b0;
        clr_we = 1'b0;
        case (state_q)
            INIT:    clr_we = 1'b1;
            RUN:     run    = 1'b1;
            default: ;
        endcase
    end

    // Gating with rst_ni keeps ready low while reset is held even when reset lands in RUN.
    assign ready_o  = run & rst_ni;
    assign acc      = valid_i & ready_o;
    assign in_range = {1'b0, req.addr} < DEPTH_W;
    assign wr_acc   = acc & req.wr;
    assign rd_acc   = acc & ~req.wr;

    assign waddr = clr_we ? clr_cnt_q : req.addr;
    always_comb begin
        for (int k = 0; k < NUM_LANES; k++) begin
            lane_we[k]    = clr_we | (wr_acc & in_range & req.be[k]);
            lane_wdata[k] = clr_we ? 8'h00 : req.wdata[8*k +: 8];
        end
    end

    assign vld_pipe = {vld_q, rd_acc};
    assign err_pipe = {err_q, rd_acc & ~in_range};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q    <= '0;
            err_q    <= '0;
            wr_err_q <= 1'b0;
        end else begin
            vld_q    <= vld_pipe[READ_LAT-1:0];
            err_q    <= err_pipe[READ_LAT-1:0];
            wr_err_q <= wr_acc & ~in_range;
        end
    end

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        mem_be_lane #(
            .DEPTH      (DEPTH),
            .ADDR_WIDTH (ADDR_WIDTH),
            .READ_LAT   (READ_LAT)
        ) u_lane (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .we_i    (lane_we[k]),
            .waddr_i (waddr),
            .wdata_i (lane_wdata[k]),
            .raddr_i (req.addr),
            .rzero_i (~in_range),
            .vld_i   (vld_pipe[READ_LAT-1:0]),
            .rdata_o (lane_rdata[k])
        );
    end

    assign rdata_o  = lane_rdata;
    assign rvalid_o = vld_pipe[READ_LAT];
    // A write error and a read response can land in the same cycle; both report on err_o.
    assign err_o    = wr_err_q | (vld_pipe[READ_LAT] & err_pipe[READ_LAT]);
endmodule

// File: tb/tb_mem_be_pipe.sv
// Two instances share one request port: A (48 words, latency 3, clear sweep) and
// B (64 words, latency 1, contents kept). A per-cycle reference model predicts both.

module tb_mem_be_pipe;
    logic        clk = 1'b0;
    logic [1:0]  rst_n;
    logic        valid_i, wr_rd_i;
    logic [5:0]  addr_i;
    logic [31:0] wdata_i;
    logic [3:0]  be_i;
    logic [1:0]  rdy, rv, er;
    logic [1:0][31:0] rd;

    always #5 clk = ~clk;

    mem_be_pipe #(.WIDTH(32), .DEPTH(48), .READ_LAT(3), .CLEAR_ON_RESET(1)) dut_a (
        .clk_i(clk), .rst_ni(rst_n[0]), .valid_i(valid_i), .ready_o(rdy[0]),
        .wr_rd_i(wr_rd_i), .addr_i(addr_i), .wdata_i(wdata_i), .be_i(be_i),
        .rdata_o(rd[0]), .rvalid_o(rv[0]), .err_o(er[0]));

    mem_be_pipe #(.WIDTH(32), .DEPTH(64), .READ_LAT(1), .CLEAR_ON_RESET(0)) dut_b (
        .clk_i(clk), .rst_ni(rst_n[1]), .valid_i(valid_i), .ready_o(rdy[1]),
        .wr_rd_i(wr_rd_i), .addr_i(addr_i), .wdata_i(wdata_i), .be_i(be_i),
        .rdata_o(rd[1]), .rvalid_o(rv[1]), .err_o(er[1]));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state
    int          DEP [2] = '{48, 64};
    int          RL  [2] = '{3, 1};
    bit          CLR [2] = '{1'b1, 1'b0};
    logic [31:0] ref_mem [2][64];
    bit          exp_rv  [2][256];
    bit          exp_er  [2][256];
    logic [31:0] exp_dat [2][256];
    int          init_left [2];
    logic [31:0] last_dat [2];
    logic [31:0] e_dat [2];
    bit [1:0]    in_rst, e_rdy, e_rv, e_err;
    int          n_chk = 0, n_fail = 0;

    task automatic step(input logic v, input logic wr, input int a, input logic [31:0] wd,
                        input logic [3:0] be);
        int k, s;
        bit inr;
        valid_i = v; wr_rd_i = wr; addr_i = a[5:0]; wdata_i = wd; be_i = be;
        k = cyc + 1;
        for (int d = 0; d < 2; d++) begin
            if (v && !in_rst[d] && init_left[d] == 0) begin
                inr = a < DEP[d];
                if (wr) begin
                    if (inr) begin
                        for (int b = 0; b < 4; b++)
                            if (be[b]) ref_mem[d][a][8*b +: 8] = wd[8*b +: 8];
                    end else begin
                        exp_er[d][k % 256] = 1'b1;
                    end
                end else begin
                    s = (k + RL[d] - 1) % 256;
                    exp_rv[d][s]  = 1'b1;
                    exp_er[d][s]  = exp_er[d][s] | !inr;
                    exp_dat[d][s] = inr ? ref_mem[d][a] : 32'h0;
                end
            end
        end
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++) begin
            if (!in_rst[d] && init_left[d] > 0) init_left[d]--;
            s = cyc % 256;
            e_rv[d]  = exp_rv[d][s];
            e_err[d] = exp_er[d][s];
            if (exp_rv[d][s]) last_dat[d] = exp_dat[d][s];
            e_dat[d] = last_dat[d];
            exp_rv[d][s] = 1'b0; exp_er[d][s] = 1'b0;
            e_rdy[d] = !in_rst[d] && init_left[d] == 0;
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 0, 32'h0, 4'h0);
    endtask

    task automatic assert_rst(input bit [1:0] m);
        valid_i = 1'b0;
        for (int d = 0; d < 2; d++) begin
            if (m[d]) begin
                rst_n[d] = 1'b0; in_rst[d] = 1'b1; init_left[d] = 0;
                for (int s = 0; s < 256; s++) begin exp_rv[d][s] = 1'b0; exp_er[d][s] = 1'b0; end
                last_dat[d] = 32'h0;
            end
        end
    endtask

    task automatic release_rst(input bit [1:0] m);
        for (int d = 0; d < 2; d++) begin
            if (m[d]) begin
                rst_n[d] = 1'b1; in_rst[d] = 1'b0;
                init_left[d] = CLR[d] ? DEP[d] : 0;
                if (CLR[d]) for (int a = 0; a < 64; a++) ref_mem[d][a] = 32'h0;
                e_rdy[d] = init_left[d] == 0;
            end
        end
    endtask

    task automatic test_reset();
        int lowcnt;
        assert_rst(2'b11);
        repeat (3) begin
            idle();
            for (int d = 0; d < 2; d++) begin
                n_chk++;
                if ({rdy[d], rv[d], er[d], rd[d]} !== 35'h0) begin
                    n_fail++;
                    $display("FAIL in_reset dut%0d cyc%0d got rdy=%b rv=%b err=%b data=%h need all zero",
                             d, cyc, rdy[d], rv[d], er[d], rd[d]);
                end
            end
        end
        release_rst(2'b11);
        #1;
        n_chk++;
        if (rdy !== 2'b10) begin
            n_fail++; $display("FAIL ready_at_release got %b need 10", rdy);
        end
        lowcnt = rdy[0] ? 0 : 1;
        for (int i = 0; i < 200 && e_rdy != 2'b11; i++) begin
            idle();
            if (!rdy[0]) lowcnt++;
            for (int d = 0; d < 2; d++) begin
                n_chk++;
                if ({rdy[d], rv[d], er[d], rd[d]} !== {e_rdy[d], e_rv[d], e_err[d], e_dat[d]}) begin
                    n_fail++;
                    $display("FAIL init dut%0d cyc%0d got rdy=%b rv=%b err=%b data=%h need %b %b %b %h",
                             d, cyc, rdy[d], rv[d], er[d], rd[d], e_rdy[d], e_rv[d], e_err[d], e_dat[d]);
                end
            end
        end
        n_chk++;
        if (lowcnt != 48) begin
            n_fail++; $display("FAIL init_length got %0d cycles need 48", lowcnt);
        end
    endtask

    task automatic test_full_write();
        int pulses [2] = '{0, 0};
        for (int n = 0; n < 132; n++) begin
            if (n < 64)       step(1'b1, 1'b1, n, 32'(n) * 32'h01010101, 4'hF);
            else if (n < 128) step(1'b1, 1'b0, n - 64, 32'h0, 4'h0);
            else              idle();
            for (int d = 0; d < 2; d++) begin
                if (rv[d]) pulses[d]++;
                n_chk++;
                if ({rdy[d], rv[d], er[d], rd[d]} !== {e_rdy[d], e_rv[d], e_err[d], e_dat[d]}) begin
                    n_fail++;
                    $display("FAIL full_rw dut%0d cyc%0d got rdy=%b rv=%b err=%b data=%h need %b %b %b %h",
                             d, cyc, rdy[d], rv[d], er[d], rd[d], e_rdy[d], e_rv[d], e_err[d], e_dat[d]);
                end
            end
        end
        for (int d = 0; d < 2; d++) begin
            n_chk++;
            if (pulses[d] != 64) begin
                n_fail++; $display("FAIL full_rw_pulses dut%0d got %0d need 64", d, pulses[d]);
            end
        end
    endtask

    task automatic test_clear();
        assert_rst(2'b01);
        idle(); idle();
        release_rst(2'b01);
        for (int i = 0; i < 200 && e_rdy != 2'b11; i++) idle();
        for (int n = 0; n < 68; n++) begin
            if (n < 64) step(1'b1, 1'b0, n, 32'h0, 4'h0);
            else        idle();
            n_chk++;
            if (rv[0] && rd[0] !== 32'h0) begin
                n_fail++; $display("FAIL clear_zero cyc%0d got %h need 00000000", cyc, rd[0]);
            end
            for (int d = 0; d < 2; d++) begin
                n_chk++;
                if ({rdy[d], rv[d], er[d], rd[d]} !== {e_rdy[d], e_rv[d], e_err[d], e_dat[d]}) begin
                    n_fail++;
                    $display("FAIL clear dut%0d cyc%0d got rdy=%b rv=%b err=%b data=%h need %b %b %b %h",
                             d, cyc, rdy[d], rv[d], er[d], rd[d], e_rdy[d], e_rv[d], e_err[d], e_dat[d]);
                end
            end
        end
    endtask

    task automatic test_byte_en();
        step(1'b1, 1'b1, 5, 32'hAABBCCDD, 4'hF);
        step(1'b1, 1'b1, 5, 32'h11223344, 4'b0101);
        step(1'b1, 1'b0, 5, 32'h0, 4'h0);
        n_chk++;
        if (rv[1] !== 1'b1 || rd[1] !== 32'hAA22CC44) begin
            n_fail++; $display("FAIL raw_merge dut1 got rv=%b data=%h need 1 aa22cc44", rv[1], rd[1]);
        end
        step(1'b1, 1'b1, 5, 32'hFFFFFFFF, 4'h0);
        step(1'b1, 1'b0, 5, 32'h0, 4'h0);
        n_chk++;
        if (rv[0] !== 1'b1 || rd[0] !== 32'hAA22CC44) begin
            n_fail++; $display("FAIL raw_merge dut0 got rv=%b data=%h need 1 aa22cc44", rv[0], rd[0]);
        end
        for (int n = 0; n < 4; n++) begin
            if (n > 0) idle();
            for (int d = 0; d < 2; d++) begin
                n_chk++;
                if ({rdy[d], rv[d], er[d], rd[d]} !== {e_rdy[d], e_rv[d], e_err[d], e_dat[d]}) begin
                    n_fail++;
                    $display("FAIL byte_en dut%0d cyc%0d got rdy=%b rv=%b err=%b data=%h need %b %b %b %h",
                             d, cyc, rdy[d], rv[d], er[d], rd[d], e_rdy[d], e_rv[d], e_err[d], e_dat[d]);
                end
            end
        end
        n_chk++;
        if (rd[0] !== 32'hAA22CC44 || rd[1] !== 32'hAA22CC44) begin
            n_fail++; $display("FAIL be_zero_noop got %h %h need aa22cc44", rd[0], rd[1]);
        end
    endtask

    task automatic test_out_of_range();
        int addrs [5] = '{50, 50, 47, 18, 2};
        for (int n = 0; n < 9; n++) begin
            if (n == 0)     step(1'b1, 1'b1, 50, 32'hDEADBEEF, 4'hF);
            else if (n < 5) step(1'b1, 1'b0, addrs[n], 32'h0, 4'h0);
            else            idle();
            if (n == 0) begin
                n_chk++;
                if (er !== 2'b01) begin
                    n_fail++; $display("FAIL oor_write_err got %b need 01", er);
                end
            end
            if (n == 3) begin
                n_chk++;
                if ({rv[0], er[0], rd[0]} !== {2'b11, 32'h0}) begin
                    n_fail++; $display("FAIL oor_read dut0 got rv=%b err=%b data=%h need 1 1 0", rv[0], er[0], rd[0]);
                end
            end
            for (int d = 0; d < 2; d++) begin
                n_chk++;
                if ({rdy[d], rv[d], er[d], rd[d]} !== {e_rdy[d], e_rv[d], e_err[d], e_dat[d]}) begin
                    n_fail++;
                    $display("FAIL oor dut%0d cyc%0d got rdy=%b rv=%b err=%b data=%h need %b %b %b %h",
                             d, cyc, rdy[d], rv[d], er[d], rd[d], e_rdy[d], e_rv[d], e_err[d], e_dat[d]);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            if (n < 396)
                step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 63)),
                     $urandom, 4'($urandom_range(0, 15)));
            else
                idle();
            for (int d = 0; d < 2; d++) begin
                n_chk++;
                if ({rdy[d], rv[d], er[d], rd[d]} !== {e_rdy[d], e_rv[d], e_err[d], e_dat[d]}) begin
                    n_fail++;
                    $display("FAIL random dut%0d cyc%0d got rdy=%b rv=%b err=%b data=%h need %b %b %b %h",
                             d, cyc, rdy[d], rv[d], er[d], rd[d], e_rdy[d], e_rv[d], e_err[d], e_dat[d]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int pulses_after;
        step(1'b1, 1'b0, 1, 32'h0, 4'h0);
        step(1'b1, 1'b0, 2, 32'h0, 4'h0);
        step(1'b1, 1'b0, 3, 32'h0, 4'h0);
        idle();
        assert_rst(2'b11);
        pulses_after = 0;
        for (int n = 0; n < 160; n++) begin
            if (n == 3)  release_rst(2'b11);
            if (n == 13) assert_rst(2'b01);
            if (n == 15) release_rst(2'b01);
            if (n < 80 || e_rdy != 2'b11) idle();
            else step(1'b1, 1'b0, (n - 80) % 64, 32'h0, 4'h0);
            if (n < 60 && rv != 2'b00) pulses_after++;
            for (int d = 0; d < 2; d++) begin
                n_chk++;
                if ({rdy[d], rv[d], er[d], rd[d]} !== {e_rdy[d], e_rv[d], e_err[d], e_dat[d]}) begin
                    n_fail++;
                    $display("FAIL reset_mid dut%0d cyc%0d got rdy=%b rv=%b err=%b data=%h need %b %b %b %h",
                             d, cyc, rdy[d], rv[d], er[d], rd[d], e_rdy[d], e_rv[d], e_err[d], e_dat[d]);
                end
            end
        end
        n_chk++;
        if (pulses_after != 0) begin
            n_fail++; $display("FAIL reset_mid_pulses got %0d need 0", pulses_after);
        end
    endtask

    initial begin
        rst_n = 2'b00; valid_i = 1'b0; wr_rd_i = 1'b0; addr_i = '0; wdata_i = '0; be_i = '0;
        in_rst = 2'b11; e_rdy = '0; e_rv = '0; e_err = '0;
        for (int d = 0; d < 2; d++) begin
            init_left[d] = 0; last_dat[d] = 32'h0; e_dat[d] = 32'h0;
            for (int s = 0; s < 256; s++) begin
                exp_rv[d][s] = 1'b0; exp_er[d][s] = 1'b0; exp_dat[d][s] = 32'h0;
            end
        end
        test_reset();
        test_full_write();
        test_clear();
        test_byte_en();
        test_out_of_range();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
